// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the RV32I core pipeline registers.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // A bubble keeps the PC fields of the previous entry and only kills the instruction.
    function automatic if_id_t make_bubble(input if_id_t cur, input logic [31:0] nop);
        if_id_t b;
        b       = cur;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Fetch PC flop with redirect/hold/increment selection and misaligned-target detection.
module pc_register
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC_VAL = RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic        hold,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic        misalign
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC_VAL;
            misalign <= 1'b0;
        end else if (redirect) begin
            // Low bits are dropped; the fault is only flagged, fetch continues aligned.
            pc       <= {target[31:2], 2'b00};
            misalign <= |target[1:0];
        end else begin
            misalign <= 1'b0;
            if (!hold) begin
                pc <= pc + 32'd4;
            end
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register; inserts NOP bubbles on redirect and imem wait.
module if_id_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC_VAL  = RESET_PC,
    parameter logic [31:0] NOP_INSTR_VAL = NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        br_sel_i,
    input  logic [31:0] br_target_i,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_instr_o,
    output logic        id_valid_o,
    output logic        misalign_o
);

    logic [31:0] pc;
    logic        pc_hold;
    if_id_t      id_q;

    // A stall freezes the PC even when imem is not ready; a redirect overrides both.
    assign pc_hold = stall_i | ~imem_ready_i;

    pc_register #(
        .RESET_PC_VAL(RESET_PC_VAL)
    ) u_pc_register (
        .clk      (clk_i),
        .rst      (rst_i),
        .redirect (br_sel_i),
        .hold     (pc_hold),
        .target   (br_target_i),
        .pc       (pc),
        .misalign (misalign_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q.pc    <= 32'd0;
            id_q.pc4   <= 32'd4;
            id_q.instr <= NOP_INSTR_VAL;
            id_q.valid <= 1'b0;
        end else if (br_sel_i) begin
            id_q <= make_bubble(id_q, NOP_INSTR_VAL);
        end else if (stall_i) begin
            id_q <= id_q;
        end else if (!imem_ready_i) begin
            id_q <= make_bubble(id_q, NOP_INSTR_VAL);
        end else begin
            id_q.pc    <= pc;
            id_q.pc4   <= pc + 32'd4;
            id_q.instr <= imem_rdata_i;
            id_q.valid <= 1'b1;
        end
    end

    assign imem_addr_o = pc;
    assign id_pc_o     = id_q.pc;
    assign id_pc4_o    = id_q.pc4;
    assign id_instr_o  = id_q.instr;
    assign id_valid_o  = id_q.valid;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage with a queue scoreboard checked by a separate monitor.
module tb_if_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, br_sel_i, imem_ready_i;
    logic [31:0] br_target_i, imem_rdata_i;
    logic [31:0] imem_addr_o, id_pc_o, id_pc4_o, id_instr_o;
    logic        id_valid_o, misalign_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst, stall, br, ready;
        logic [31:0] tgt, rdata;
        logic [31:0] addr, idpc, pc4, instr;
        logic        v, m;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] addr, idpc, pc4, instr;
        logic        v, m;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    if_id_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .br_sel_i     (br_sel_i),
        .br_target_i  (br_target_i),
        .imem_ready_i (imem_ready_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_addr_o  (imem_addr_o),
        .id_pc_o      (id_pc_o),
        .id_pc4_o     (id_pc4_o),
        .id_instr_o   (id_instr_o),
        .id_valid_o   (id_valid_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic add(input logic rst, input logic stall, input logic br, input logic [31:0] tgt,
                       input logic ready, input logic [31:0] rdata,
                       input logic [31:0] addr, input logic [31:0] idpc, input logic [31:0] pc4,
                       input logic [31:0] instr, input logic v, input logic m);
        vec_t x;
        x.rst = rst; x.stall = stall; x.br = br; x.tgt = tgt; x.ready = ready; x.rdata = rdata;
        x.addr = addr; x.idpc = idpc; x.pc4 = pc4; x.instr = instr; x.v = v; x.m = m;
        vecs.push_back(x);
    endtask

    task automatic drive(input vec_t x);
        rst_i        = x.rst;
        stall_i      = x.stall;
        br_sel_i     = x.br;
        br_target_i  = x.tgt;
        imem_ready_i = x.ready;
        imem_rdata_i = x.rdata;
    endtask

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, req);
        end
    endtask

    // Monitor: every sampled cycle with a pending expectation is compared.
    initial begin
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk(e.idx, "imem_addr", imem_addr_o, e.addr);
                chk(e.idx, "id_pc",     id_pc_o,     e.idpc);
                chk(e.idx, "id_pc4",    id_pc4_o,    e.pc4);
                chk(e.idx, "id_instr",  id_instr_o,  e.instr);
                chk(e.idx, "id_valid",  {31'd0, id_valid_o}, {31'd0, e.v});
                chk(e.idx, "misalign",  {31'd0, misalign_o}, {31'd0, e.m});
            end
        end
    end

    initial begin
        //   rst stall br  target        rdy rdata           addr          id_pc         id_pc4        instr         v  m
        // reset held two cycles
        add(1, 0, 0, 32'h0,         1, 32'h0,         32'h0,         32'h0,         32'h4,         32'h13,        0, 0);
        add(1, 0, 0, 32'h0,         1, 32'h0,         32'h0,         32'h0,         32'h4,         32'h13,        0, 0);
        // first fetch and sequential stream
        add(0, 0, 0, 32'h0,         1, 32'h00A98933,  32'h4,         32'h0,         32'h4,         32'h00A98933,  1, 0);
        add(0, 0, 0, 32'h0,         1, 32'h00400093,  32'h8,         32'h4,         32'h8,         32'h00400093,  1, 0);
        // stall at pc=8 for two cycles, then release
        add(0, 1, 0, 32'h0,         1, 32'h00800113,  32'h8,         32'h4,         32'h8,         32'h00400093,  1, 0);
        add(0, 1, 0, 32'h0,         1, 32'h00800113,  32'h8,         32'h4,         32'h8,         32'h00400093,  1, 0);
        add(0, 0, 0, 32'h0,         1, 32'h00800113,  32'hC,         32'h8,         32'hC,         32'h00800113,  1, 0);
        add(0, 0, 0, 32'h0,         1, 32'h00C00193,  32'h10,        32'hC,         32'h10,        32'h00C00193,  1, 0);
        // redirect with simultaneous stall: redirect wins, ID squashed
        add(0, 1, 1, 32'h208,       1, 32'h0,         32'h208,       32'hC,         32'h10,        32'h13,        0, 0);
        add(0, 0, 0, 32'h0,         1, 32'h20800213,  32'h20C,       32'h208,       32'h20C,       32'h20800213,  1, 0);
        // misaligned redirect pulses misalign for one cycle
        add(0, 0, 1, 32'h211,       1, 32'h0,         32'h210,       32'h208,       32'h20C,       32'h13,        0, 1);
        add(0, 0, 0, 32'h0,         1, 32'h00000293,  32'h214,       32'h210,       32'h214,       32'h00000293,  1, 0);
        // misaligned redirect to top of memory while imem not ready
        add(0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0,         32'hFFFF_FFFC, 32'h210,       32'h214,       32'h13,        0, 1);
        // three wait cycles: pc holds, bubbles
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFFC, 32'h210,       32'h214,       32'h13,        0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFFC, 32'h210,       32'h214,       32'h13,        0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFFC, 32'h210,       32'h214,       32'h13,        0, 0);
        // ready: wrap of pc+4 to zero
        add(0, 0, 0, 32'h0,         1, 32'h00100313,  32'h0,         32'hFFFF_FFFC, 32'h0,         32'h00100313,  1, 0);
        add(0, 0, 0, 32'h0,         1, 32'h00200393,  32'h4,         32'h0,         32'h4,         32'h00200393,  1, 0);
        // reset beats stall, then reset beats misaligned redirect
        add(1, 1, 0, 32'h0,         1, 32'h0,         32'h0,         32'h0,         32'h4,         32'h13,        0, 0);
        add(1, 0, 1, 32'h103,       1, 32'h0,         32'h0,         32'h0,         32'h4,         32'h13,        0, 0);
        add(0, 0, 0, 32'h0,         1, 32'h00A98933,  32'h4,         32'h0,         32'h4,         32'h00A98933,  1, 0);
        // stall while not ready: hold, not a bubble
        add(0, 1, 0, 32'h0,         0, 32'h0,         32'h4,         32'h0,         32'h4,         32'h00A98933,  1, 0);

        drive(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(posedge clk_i);
            e.idx = i; e.addr = vecs[i].addr; e.idpc = vecs[i].idpc; e.pc4 = vecs[i].pc4;
            e.instr = vecs[i].instr; e.v = vecs[i].v; e.m = vecs[i].m;
            sb.push_back(e);
            #1;
            if (i + 1 < vecs.size()) drive(vecs[i + 1]);
        end
        repeat (2) @(negedge clk_i);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
